// File: rtl/cell_window_builder_pkg.sv
// Shared pixel and cell definitions for the cell-processing pipeline.
// A cell packs a 3x3 pixel window, with pixel k = 3*r + c in slice k.
package CellProcessingPkg;

   typedef logic [7:0] pixel_t;

   localparam int PIXEL_W   = $bits(pixel_t);
   localparam int cellDepth = 9 * PIXEL_W;

   typedef logic [cellDepth-1:0] cell_t;

   function automatic int cell_idx(input int r, input int c);
      return 3 * r + c;
   endfunction

endpackage

// File: rtl/cell_window_builder_line_buffer.sv
// Single-port line store holding one image row.
// The read is combinational, so the old entry is visible in the same cycle that it is overwritten.
module line_buffer
   import CellProcessingPkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  pixel_t            wdata,
   output pixel_t            rdata
);

   pixel_t mem [DEPTH];

   assign rdata = mem[addr];

   // Contents are deliberately not reset; output gating hides stale rows.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

endmodule

// File: rtl/cell_window_builder.sv
// Turns a raster pixel stream into 3x3 windows (cells) using two line buffers.
// One cell is emitted per accepted pixel once row >= 2 and col >= 2.
module cell_window_builder
   import CellProcessingPkg::*;
#(
   parameter int IMG_WIDTH  = 64,
   parameter int IMG_HEIGHT = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pix_valid,
   output logic                 pix_ready,
   input  pixel_t               pix_data,
   input  logic                 pix_sof,
   output logic                 cell_valid,
   input  logic                 cell_ready,
   output logic [cellDepth-1:0] cell_data,
   output logic                 frame_done
);

   localparam int COL_W = $clog2(IMG_WIDTH);
   localparam int ROW_W = $clog2(IMG_HEIGHT);

   logic [COL_W-1:0] col_r;
   logic [ROW_W-1:0] row_r;
   logic [COL_W-1:0] cur_col_s;
   logic [ROW_W-1:0] cur_row_s;
   cell_t            win_r;
   cell_t            win_next_s;
   pixel_t           buf0_rd_s;
   pixel_t           buf1_rd_s;
   pixel_t           col_in_s [3];
   logic             accept_s;
   logic             emit_s;
   logic             last_pix_s;
   logic             line_end_s;

   assign pix_ready  = !cell_valid || cell_ready;
   assign accept_s   = pix_valid && pix_ready;
   assign cur_col_s  = pix_sof ? '0 : col_r;
   assign cur_row_s  = pix_sof ? '0 : row_r;
   assign line_end_s = (cur_col_s == COL_W'(IMG_WIDTH - 1));
   assign last_pix_s = line_end_s && (cur_row_s == ROW_W'(IMG_HEIGHT - 1));
   assign emit_s     = (cur_row_s >= ROW_W'(2)) && (cur_col_s >= COL_W'(2));

   // Buffer 0 holds row r-2 and is fed from buffer 1 (row r-1) as the row advances.
   line_buffer #(.DEPTH(IMG_WIDTH), .ADDR_W(COL_W)) u_buf0 (
      .clk   (clk),
      .we    (accept_s),
      .addr  (cur_col_s),
      .wdata (buf1_rd_s),
      .rdata (buf0_rd_s)
   );

   line_buffer #(.DEPTH(IMG_WIDTH), .ADDR_W(COL_W)) u_buf1 (
      .clk   (clk),
      .we    (accept_s),
      .addr  (cur_col_s),
      .wdata (pix_data),
      .rdata (buf1_rd_s)
   );

   assign col_in_s[0] = buf0_rd_s;
   assign col_in_s[1] = buf1_rd_s;
   assign col_in_s[2] = pix_data;

   // Window shifted left by one column with the new column entering on the right.
   always_comb begin
      win_next_s = '0;
      for (int r = 0; r < 3; r++) begin
         win_next_s[cell_idx(r, 0)*PIXEL_W +: PIXEL_W] = win_r[cell_idx(r, 1)*PIXEL_W +: PIXEL_W];
         win_next_s[cell_idx(r, 1)*PIXEL_W +: PIXEL_W] = win_r[cell_idx(r, 2)*PIXEL_W +: PIXEL_W];
         win_next_s[cell_idx(r, 2)*PIXEL_W +: PIXEL_W] = col_in_s[r];
      end
   end

   // Position counters, window registers and the output handshake.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_r      <= '0;
         row_r      <= '0;
         win_r      <= '0;
         cell_valid <= 1'b0;
         cell_data  <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (accept_s) begin
            win_r      <= win_next_s;
            frame_done <= last_pix_s;
            if (last_pix_s) begin
               col_r <= '0;
               row_r <= '0;
            end else if (line_end_s) begin
               col_r <= '0;
               row_r <= cur_row_s + ROW_W'(1);
            end else begin
               col_r <= cur_col_s + COL_W'(1);
               row_r <= cur_row_s;
            end
         end
         if (accept_s && emit_s) begin
            cell_valid <= 1'b1;
            cell_data  <= win_next_s;
         end else if (cell_ready) begin
            cell_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cell_window_builder.sv
// Scoreboard bench for cell_window_builder on an 8x6 ramp image.
module tb_cell_window_builder;
   import CellProcessingPkg::*;

   localparam int W = 8;
   localparam int H = 6;

   logic   clk;
   logic   rst;
   logic   pix_valid;
   logic   pix_ready;
   pixel_t pix_data;
   logic   pix_sof;
   logic   cell_valid;
   logic   cell_ready;
   logic [cellDepth-1:0] cell_data;
   logic   frame_done;

   int     n_checks;
   int     n_fail;
   cell_t  q [$];
   cell_t  log_q [$];
   cell_t  ref_q [$];
   pixel_t img [H][W];
   int     m_row;
   int     m_col;
   logic   exp_fd;
   logic   stalled;
   cell_t  hold;

   cell_window_builder #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk        (clk),
      .rst        (rst),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .pix_data   (pix_data),
      .pix_sof    (pix_sof),
      .cell_valid (cell_valid),
      .cell_ready (cell_ready),
      .cell_data  (cell_data),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [cellDepth-1:0] got, input logic [cellDepth-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: a plain image array addressed by its own counters.
   task automatic model_accept(input pixel_t d, input logic sof);
      cell_t c;
      if (sof) begin
         m_row = 0;
         m_col = 0;
      end
      img[m_row][m_col] = d;
      if (m_row >= 2 && m_col >= 2) begin
         c = '0;
         for (int r = 0; r < 3; r++)
            for (int cc = 0; cc < 3; cc++)
               c[(3*r+cc)*PIXEL_W +: PIXEL_W] = img[m_row-2+r][m_col-2+cc];
         q.push_back(c);
      end
      if (m_row == H-1 && m_col == W-1) begin
         exp_fd = 1'b1;
         m_row  = 0;
         m_col  = 0;
      end else if (m_col == W-1) begin
         m_col = 0;
         m_row++;
      end else begin
         m_col++;
      end
   endtask

   task automatic drive_cycle(input logic v, input pixel_t d, input logic sof, input logic rnd, output logic acc);
      cell_t e;
      @(negedge clk);
      pix_valid  = v;
      pix_data   = d;
      pix_sof    = sof;
      cell_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk("frame_done", frame_done, exp_fd);
      if (stalled) begin
         chk("stall_valid", cell_valid, 1'b1);
         chk("stall_data", cell_data, hold);
      end
      if (cell_valid && !cell_ready) chk("stall_no_accept", pix_ready, 1'b0);
      if (cell_valid && cell_ready) begin
         chk("cell_expected", q.size() > 0, 1'b1);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("cell_data", cell_data, e);
            log_q.push_back(cell_data);
         end
      end
      stalled = cell_valid && !cell_ready;
      hold    = cell_data;
      acc     = v && pix_ready;
      exp_fd  = 1'b0;
      if (acc) model_accept(d, sof);
   endtask

   task automatic send_pixel(input pixel_t d, input logic sof, input logic rnd);
      logic acc;
      int   n;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 200) begin
         drive_cycle(1'b1, d, sof, rnd, acc);
         n++;
      end
      if (!acc) chk("accept_timeout", acc, 1'b1);
   endtask

   task automatic drain();
      logic acc;
      repeat (8) drive_cycle(1'b0, '0, 1'b0, 1'b0, acc);
      chk("queue_empty", q.size(), 0);
   endtask

   task automatic send_frame(input int n_pix, input logic rnd);
      for (int i = 0; i < n_pix; i++) send_pixel(pixel_t'(i), i == 0, rnd);
      drain();
   endtask

   task automatic cmp_ref(input string tag);
      chk({tag, "_count"}, log_q.size(), ref_q.size());
      for (int i = 0; i < log_q.size() && i < ref_q.size(); i++) chk(tag, log_q[i], ref_q[i]);
   endtask

   initial begin
      int    first_k [9];
      int    wrap_k [9];
      cell_t c0;
      cell_t c1;
      first_k = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
      wrap_k  = '{8, 9, 10, 16, 17, 18, 24, 25, 26};
      n_checks = 0; n_fail = 0;
      m_row = 0; m_col = 0; exp_fd = 1'b0; stalled = 1'b0; hold = '0;
      rst = 1'b0; pix_valid = 1'b0; pix_data = '0; pix_sof = 1'b0; cell_ready = 1'b1;

      // Reset state
      #2;
      chk("ready_in_reset", pix_ready, 1'b1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("reset_valid", cell_valid, 1'b0);
      chk("reset_ready", pix_ready, 1'b1);
      chk("reset_data", cell_data, '0);
      chk("reset_frame_done", frame_done, 1'b0);

      // Ramp frame, always ready; includes row-wrap check
      log_q.delete();
      send_frame(W*H, 1'b0);
      chk("ramp_cells", log_q.size(), 24);
      c0 = '0; c1 = '0;
      for (int k = 0; k < 9; k++) begin
         c0[k*PIXEL_W +: PIXEL_W] = pixel_t'(first_k[k]);
         c1[k*PIXEL_W +: PIXEL_W] = pixel_t'(wrap_k[k]);
      end
      if (log_q.size() > 6) begin
         chk("first_cell", log_q[0], c0);
         chk("row_wrap_cell", log_q[6], c1);
      end
      ref_q = log_q;

      // Random back-pressure
      log_q.delete();
      send_frame(W*H, 1'b1);
      cmp_ref("stall_seq");

      // Mid-frame sof at (3,4) abandons the partial frame
      send_frame(3*W + 4, 1'b0);
      log_q.delete();
      send_frame(W*H, 1'b0);
      cmp_ref("sof_seq");

      // Reset while a cell is pending at (4,5)
      for (int i = 0; i < 4*W + 6; i++) send_pixel(pixel_t'(i), i == 0, 1'b0);
      @(negedge clk);
      pix_valid  = 1'b0;
      cell_ready = 1'b0;
      #1;
      chk("pre_reset_valid", cell_valid, 1'b1);
      rst = 1'b0;
      #1;
      chk("reset_drop_valid", cell_valid, 1'b0);
      chk("reset_drop_data", cell_data, '0);
      chk("reset_drop_ready", pix_ready, 1'b1);
      chk("pending_cells", q.size(), 1);
      q.delete();
      stalled = 1'b0; exp_fd = 1'b0; m_row = 0; m_col = 0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      log_q.delete();
      send_frame(W*H, 1'b0);
      cmp_ref("post_reset_seq");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
